if_fetch_unit: RTL

- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a request/acknowledge instruction-memory port that may take zero or more wait cycles.
- Presents the fetched instruction and PC+4 to the IF/ID register, with NOP bubbles when nothing is valid.
- Handles the hazard unit's hold by buffering one instruction, and branch/jump redirects by discarding wrong-path fetches.

---
 rtl/if_fetch_unit_pkg.sv | 20 ++
 rtl/if_fetch_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// NOP encoding, PC width and a word-alignment helper.
package if_fetch_unit_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] NOP_ENC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_BUFFERED = 2'd1,
        ST_DRAIN    = 2'd2
    } fetch_state_e;

    // Redirect targets are always word aligned; the low two bits are dropped.
    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
//
// Owns the PC and drives a req/ack instruction-memory port. imem_req is a
// level: once raised, imem_addr is held until the cycle imem_ack=1, and the
// memory may ack in the very first cycle of a request. Only one request is
// ever outstanding. instr_valid=1 marks instr_out/pc_plus4_out as a real
// instruction; IF/ID captures it only when hold=0.
//
// A one-entry skid buffer absorbs an instruction that arrives while IF/ID is
// held. A redirect that lands while a fetch is still waiting cannot cancel
// that fetch, so the FSM parks in DRAIN until the wrong-path ack arrives and
// throws the data away before fetching from the remembered target.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [PC_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_rdata,
    output logic [PC_W-1:0] instr_out,
    output logic [PC_W-1:0] pc_plus4_out,
    output logic            instr_valid,
    output fetch_state_e    dbg_state
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] buf_instr_q, buf_instr_d;
    logic [PC_W-1:0] buf_pc4_q, buf_pc4_d;
    logic [PC_W-1:0] redir_q, redir_d;

    logic            redir_active;
    logic [PC_W-1:0] redir_target;
    logic [PC_W-1:0] pc_plus4;

    // Branch wins over jump; target is forced to a word boundary.
    always_comb begin
        redir_active = branch_taken | jump;
        redir_target = align_word(branch_taken ? branch_target : jump_target);
        pc_plus4     = pc_q + 32'd4;
    end

    // State, PC, skid buffer and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            buf_instr_q <= NOP_INSTR;
            buf_pc4_q   <= RESET_PC + 32'd4;
            redir_q     <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            redir_q     <= redir_d;
        end
    end

    // Next-state and datapath updates; a redirect always takes precedence over hold.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        redir_d     = redir_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    if (redir_active) begin
                        // Presented instruction is wrong-path; IF/ID flush kills it.
                        pc_d = redir_target;
                    end else if (hold) begin
                        buf_instr_d = imem_rdata;
                        buf_pc4_d   = pc_plus4;
                        pc_d        = pc_plus4;
                        state_d     = ST_BUFFERED;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end else if (redir_active) begin
                    redir_d = redir_target;
                    state_d = ST_DRAIN;
                end
            end
            ST_BUFFERED: begin
                if (redir_active) begin
                    pc_d    = redir_target;
                    state_d = ST_FETCH;
                end else if (!hold) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    // A redirect arriving with the draining ack is the newest target.
                    pc_d    = redir_active ? redir_target : redir_q;
                    state_d = ST_FETCH;
                end else if (redir_active) begin
                    redir_d = redir_target;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Outputs decoded from state plus the same-cycle ack; reset forces a quiet port.
    always_comb begin
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        instr_out    = NOP_INSTR;
        pc_plus4_out = pc_plus4;
        instr_valid  = 1'b0;
        dbg_state    = state_q;
        if (!rst_n) begin
            imem_addr    = RESET_PC;
            pc_plus4_out = RESET_PC + 32'd4;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        instr_out   = imem_rdata;
                        instr_valid = 1'b1;
                    end
                end
                ST_BUFFERED: begin
                    instr_out    = buf_instr_q;
                    pc_plus4_out = buf_pc4_q;
                    instr_valid  = 1'b1;
                end
                ST_DRAIN: begin
                    imem_req = 1'b1;
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

endmodule
